// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Brief    : Host byte stream and BRAM port A bundle for the instruction loader.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = 13
) ();
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_din;

    // Host / bench side
    modport master (
        output s_valid, s_data,
        input  s_ready, bram_en, bram_we, bram_addr, bram_din
    );

    // Loader side
    modport slave (
        input  s_valid, s_data,
        output s_ready, bram_en, bram_we, bram_addr, bram_din
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Packs a length-prefixed host byte stream into 32-bit words and
//            writes them into the instruction BRAM; IMEM_LOADER_CHECKSUM_EN
//            adds a trailing XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int                ADDR_W    = 13,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    input  wire logic     start,
    imem_loader_if.slave  bus,
    output logic          core_en,
    output logic          busy,
    output logic          err
);

    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, HDR = 3'd1, DATA = 3'd2, WR = 3'd3,
        DONE = 3'd4, ERR = 3'd5, CSUM = 3'd6
    } state_t;
    localparam state_t END_STATE = CSUM;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, HDR = 3'd1, DATA = 3'd2, WR = 3'd3,
        DONE = 3'd4, ERR = 3'd5
    } state_t;
    localparam state_t END_STATE = DONE;
`endif

    state_t            r_state;
    state_t            w_state_nx;
    logic [1:0]        r_idx;
    logic [31:0]       r_word;
    logic [31:0]       r_n;
    logic [31:0]       r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              w_ready;
    logic              w_accept;
    logic [31:0]       w_full;
    logic [31:0]       w_cnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign w_ready = (r_state == HDR) || (r_state == DATA) || (r_state == CSUM);
`else
    assign w_ready = (r_state == HDR) || (r_state == DATA);
`endif
    // start wins over a simultaneous handshake; that byte is dropped
    assign w_accept  = bus.s_valid & w_ready & ~start;
    assign w_full    = {bus.s_data, r_word[23:0]};
    assign w_cnt_inc = r_cnt + 32'd1;

    assign bus.s_ready   = w_ready;
    assign bus.bram_addr = r_addr;
    assign bus.bram_din  = r_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        bus.bram_en = 1'b0;
        bus.bram_we = 1'b0;
        core_en     = 1'b0;
        busy        = 1'b0;
        err         = 1'b0;
        case (r_state)
            IDLE: ;
            HDR: begin
                busy = 1'b1;
                if (w_accept && (r_idx == 2'd3)) begin
                    if (w_full == 32'd0) begin
                        w_state_nx = END_STATE;
                    end else if ({1'b0, w_full} > MAX_WORDS) begin
                        w_state_nx = ERR;
                    end else begin
                        w_state_nx = DATA;
                    end
                end
            end
            DATA: begin
                busy = 1'b1;
                if (w_accept && (r_idx == 2'd3)) begin
                    w_state_nx = WR;
                end
            end
            WR: begin
                busy        = 1'b1;
                bus.bram_en = 1'b1;
                bus.bram_we = 1'b1;
                w_state_nx  = (w_cnt_inc == r_n) ? END_STATE : DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                busy = 1'b1;
                if (w_accept) begin
                    w_state_nx = (bus.s_data == r_csum) ? DONE : ERR;
                end
            end
`endif
            DONE: core_en = 1'b1;
            ERR:  err     = 1'b1;
            default: w_state_nx = IDLE;
        endcase
        if (start) begin
            w_state_nx = HDR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx  <= 2'd0;
            r_word <= 32'd0;
            r_n    <= 32'd0;
            r_cnt  <= 32'd0;
            r_addr <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum <= 8'd0;
`endif
        end else if (start) begin
            r_idx  <= 2'd0;
            r_word <= 32'd0;
            r_n    <= 32'd0;
            r_cnt  <= 32'd0;
            r_addr <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum <= 8'd0;
`endif
        end else begin
            case (r_state)
                HDR: begin
                    if (w_accept) begin
                        r_word[{r_idx, 3'b000} +: 8] <= bus.s_data;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_n    <= w_full;
                            r_addr <= BASE_ADDR;
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_word[{r_idx, 3'b000} +: 8] <= bus.s_data;
                        r_idx <= r_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ bus.s_data;
`endif
                    end
                end
                WR: begin
                    r_addr <= r_addr + 1'b1;
                    r_cnt  <= w_cnt_inc;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed self-checking bench for imem_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic clk;
    logic rst_n;
    logic start;
    logic core_en;
    logic busy;
    logic err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int viol     = 0;
    logic [12:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader_if #(.ADDR_W(13)) bus ();

    imem_loader #(.ADDR_W(13), .BASE_ADDR(13'd0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bus     (bus),
        .core_en (core_en),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus.bram_we) begin
            wr_addr.push_back(bus.bram_addr);
            wr_data.push_back(bus.bram_din);
        end
        // while loading, ready must be low exactly in the write cycle
        if (busy && (bus.s_ready == bus.bram_we)) viol <= viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic got;
        int   n;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            got = bus.s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) check("send_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic idle();
        bus.s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.s_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, {31'd0, bus.s_ready}, 32'd0);
        check({tag, "_bram_en"}, {31'd0, bus.bram_en}, 32'd0);
        check({tag, "_bram_we"}, {31'd0, bus.bram_we}, 32'd0);
        check({tag, "_addr"},    {19'd0, bus.bram_addr}, 32'd0);
        check({tag, "_din"},     bus.bram_din, 32'd0);
        check({tag, "_core_en"}, {31'd0, core_en}, 32'd0);
        check({tag, "_busy"},    {31'd0, busy}, 32'd0);
        check({tag, "_err"},     {31'd0, err}, 32'd0);
    endtask

    initial begin
        int t0;
        rst_n       = 1'b0;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // two-word image
        pulse_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_ready", {31'd0, bus.s_ready}, 32'd1);
        send_word(32'd2);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h90);
`endif
        idle();
        wait_idle("t1_done");
        check("t1_nwr",   wr_addr.size(), 32'd2);
        check("t1_a0",    {19'd0, wr_addr[0]}, 32'd0);
        check("t1_d0",    wr_data[0], 32'h0000_0013);
        check("t1_a1",    {19'd0, wr_addr[1]}, 32'd1);
        check("t1_d1",    wr_data[1], 32'h0010_0093);
        check("t1_core",  {31'd0, core_en}, 32'd1);
        check("t1_err",   {31'd0, err}, 32'd0);

        // continuous streaming, three words
        wr_addr.delete();
        wr_data.delete();
        viol = 0;
        pulse_start();
        send_word(32'd3);
        t0 = cyc;
        send_word(32'h0403_0201);
        send_word(32'h0807_0605);
        send_word(32'h0C0B_0A09);
        check("t2_cycles", cyc - t0, 32'd14);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h0C);
`endif
        idle();
        wait_idle("t2_done");
        check("t2_nwr",  wr_addr.size(), 32'd3);
        check("t2_a2",   {19'd0, wr_addr[2]}, 32'd2);
        check("t2_d0",   wr_data[0], 32'h0403_0201);
        check("t2_d1",   wr_data[1], 32'h0807_0605);
        check("t2_d2",   wr_data[2], 32'h0C0B_0A09);
        check("t2_ready_in_wr", viol, 32'd0);
        check("t2_core", {31'd0, core_en}, 32'd1);

        // empty image
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_word(32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t3_csum_wait", {31'd0, busy}, 32'd1);
        send_byte(8'h00);
`endif
        idle();
        check("t3_core", {31'd0, core_en}, 32'd1);
        check("t3_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t3_nwr", wr_addr.size(), 32'd0);

        // oversize header: 8193 words
        pulse_start();
        send_word(32'd8193);
        idle();
        check("t4_err",  {31'd0, err}, 32'd1);
        check("t4_core", {31'd0, core_en}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_err_sticky", {31'd0, err}, 32'd1);
        check("t4_nwr", wr_addr.size(), 32'd0);
        pulse_start();
        check("t4_err_clr", {31'd0, err}, 32'd0);
        check("t4_busy2",   {31'd0, busy}, 32'd1);
        send_word(32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        idle();
        check("t4_core2", {31'd0, core_en}, 32'd1);

        // restart mid-word
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_word(32'd2);
        send_word(32'h1122_3344);
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle();
        repeat (2) @(posedge clk);
        #1;
        pulse_start();
        check("t5_core_clr", {31'd0, core_en}, 32'd0);
        send_word(32'd1);
        send_word(32'hCAFE_0001);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h35);
`endif
        idle();
        wait_idle("t5_done");
        check("t5_nwr", wr_addr.size(), 32'd2);
        check("t5_d0",  wr_data[0], 32'h1122_3344);
        check("t5_a1",  {19'd0, wr_addr[1]}, 32'd0);
        check("t5_d1",  wr_data[1], 32'hCAFE_0001);
        check("t5_core", {31'd0, core_en}, 32'd1);

        // reset mid-DATA
        pulse_start();
        send_word(32'd1);
        send_byte(8'h13);
        send_byte(8'h00);
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("t6");
        rst_n = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        repeat (10) @(posedge clk);
        #1;
        check("t6_nwr",  wr_addr.size(), 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start();
        send_word(32'd1);
        send_word(32'h0000_0013);
        send_byte(8'h13);
        idle();
        wait_idle("t7_done");
        check("t7_core", {31'd0, core_en}, 32'd1);
        check("t7_err",  {31'd0, err}, 32'd0);
        pulse_start();
        send_word(32'd1);
        send_word(32'h0000_0013);
        send_byte(8'h12);
        idle();
        wait_idle("t7_done_bad");
        check("t7_bad_err",  {31'd0, err}, 32'd1);
        check("t7_bad_core", {31'd0, core_en}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: takes a byte stream from the PS/host link, packs it into 32-bit words and writes them into the instruction BRAM write port.
- The fetch stage reads the same BRAM; core_en holds fetch stalled until a complete image is loaded.
- Sits between the host byte channel and BRAM port A, alongside the core top.

Parameters:
- ADDR_W, 13, BRAM word-address width; capacity MAX_WORDS = 2**ADDR_W.
- BASE_ADDR, 0, first word address written (ADDR_W bits).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle pulse; begins a new load
- s_valid  in  1  host byte valid
- s_data  in  8  host byte
- s_ready  out  1  loader accepts byte when s_valid & s_ready
- bram_en  out  1  BRAM port enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_W  BRAM word address
- bram_din  out  32  BRAM write data
- core_en  out  1  1 = image valid, fetch may run
- busy  out  1  load in progress
- err  out  1  sticky load error until next start or reset

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; s_ready=0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0, core_en=0, busy=0, err=0, all counters and byte index cleared. Reset mid-load abandons the load; no further BRAM writes.
- States: IDLE, HDR, DATA, WR, DONE, ERR.
- IDLE: s_ready=0. start -> HDR, busy=1, core_en=0, err=0.
- HDR: s_ready=1; accept 4 bytes, little-endian, into word count N (32 bits).
  - N==0 -> DONE.
  - N>MAX_WORDS -> ERR.
  - Otherwise -> DATA; address = BASE_ADDR.
- DATA: s_ready=1; accept bytes little-endian into a word (first byte = bits 7:0). On acceptance of the 4th byte -> WR.
- WR (exactly one cycle): s_ready=0, bram_en=1, bram_we=1, bram_din=assembled word, bram_addr=current address. The write issues the cycle after the 4th byte is accepted.
  - Then increment address (wraps modulo 2**ADDR_W) and the words-written counter.
  - Counter==N -> DONE; else -> DATA.
- DONE: busy=0, core_en=1, s_ready=0.
- ERR: busy=0, core_en=0, err=1, s_ready=0.
- bram_en and bram_we are 0 in every state except WR.
- start in any state, including mid-load, restarts at HDR: core_en=0, err=0, byte index and counters cleared. A partial word is discarded. start takes priority over a simultaneous byte acceptance, and that byte is dropped.
- A byte presented while s_ready=0 is not consumed; the host holds s_valid and s_data stable until accepted.
- Idle bytes (s_valid=0) may appear anywhere; there is no timeout.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- With it:
  - After the N-th write, the state machine enters a CSUM state with s_ready=1 and accepts one trailing byte.
  - Expected value = XOR of every data byte (header excluded).
  - Match -> DONE; mismatch -> ERR.
  - N==0: a trailing byte is still required and must equal 0x00.
  - Words already written to the BRAM are not undone on error.
- Without it: no CSUM state; behaviour is exactly as above.

Test Plan:
- Reset, then start; header 02 00 00 00; bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013 @0 and 0x00100093 @1, each bram_we for one cycle; then core_en=1, busy=0.
- Host holds s_valid=1 continuously -> s_ready=0 exactly in each WR cycle; no byte lost or duplicated; 3 words take 15 accept/write cycles after the header.
- Header 00 00 00 00 -> DONE right after the 4th header byte; no BRAM write; core_en=1.
- ADDR_W=13 with header 01 20 00 00 (N=8193) -> ERR, err=1, core_en=0, no write; a following start clears err.
- start after 2 data bytes of word 1 -> partial word dropped; the reload writes from BASE_ADDR again. rst_n=0 mid-DATA -> all outputs return to reset values the next cycle.
- With IMEM_LOADER_CHECKSUM_EN: N=1, bytes 13 00 00 00, checksum 13 -> DONE. The same load with checksum 12 -> ERR, err=1, core_en=0.
